// File: rtl/row_pkg.sv
// rtl/row_pkg.sv - shared row count, address width and FSM state type
package row_pkg;

    localparam int N_ROWS = 8;
    localparam int ROW_AW = 3;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_priority_encoder.sv
// rtl/rr_priority_encoder.sv - round-robin priority encoder starting the search at ptr
module rr_priority_encoder
    import row_pkg::*;
#(
    parameter int N  = N_ROWS,
    parameter int AW = ROW_AW
) (
    input  logic [N-1:0]  pending,
    input  logic [AW-1:0] ptr,
    output logic [AW-1:0] idx,
    output logic          found
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [AW-1:0]  offset;

    // Rotate so bit ptr lands at position 0, take the lowest set bit,
    // then add ptr back; AW-bit addition wraps because N is a power of two.
    always_comb begin
        doubled = {pending, pending} >> ptr;
        rotated = doubled[N-1:0];
        offset  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = AW'(i);
            end
        end
        found = |rotated;
        idx   = offset + ptr;
    end

endmodule

// File: rtl/row_request_encoder.sv
// rtl/row_request_encoder.sv - sticky multi-hot row requests to round-robin binary grants
module row_request_encoder
    import row_pkg::*;
#(
    parameter int N  = N_ROWS,
    parameter int AW = ROW_AW
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          ready,
    output logic [AW-1:0] addr_out,
    output logic          valid,
    output logic [N-1:0]  pending,
    output logic          busy
);

    state_t        state;
    logic [AW-1:0] ptr;
    logic [N-1:0]  clr;
    logic [AW-1:0] next_idx;
    logic          next_found;

    rr_priority_encoder #(
        .N  (N),
        .AW (AW)
    ) u_rr_priority_encoder (
        .pending (pending),
        .ptr     (ptr),
        .idx     (next_idx),
        .found   (next_found)
    );

    // Only the accepted row is cleared; a same-edge request re-sets it below.
    always_comb begin
        clr = '0;
        if (valid && ready) begin
            clr = N'(1) << addr_out;
        end
    end

    assign busy = (|pending) | valid;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            ptr      <= '0;
            addr_out <= '0;
            valid    <= 1'b0;
            state    <= IDLE;
        end else begin
            pending <= (pending & ~clr) | req;
            case (state)
                IDLE: begin
                    if (next_found) begin
                        addr_out <= next_idx;
                        valid    <= 1'b1;
                        state    <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ready) begin
                        ptr   <= addr_out + AW'(1);
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_request_encoder.sv
// tb/tb_row_request_encoder.sv - scoreboard bench for row_request_encoder
module tb_row_request_encoder;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       ready;
    logic [2:0] addr_out;
    logic       valid;
    logic [7:0] pending;
    logic       busy;

    int n_checks;
    int n_fail;
    int exp_q[$];

    row_request_encoder dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .req      (req),
        .ready    (ready),
        .addr_out (addr_out),
        .valid    (valid),
        .pending  (pending),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d grants outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every accepted grant must match the oldest expected address.
    always @(negedge clk) begin
        if (!reset && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL grant_unexpected: got addr %0d, required no grant", addr_out);
            end else begin
                check("grant_addr", int'(addr_out), exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        req      = 8'h00;
        ready    = 1'b0;
        #1;
        check("rst_valid", int'(valid), 0);
        check("rst_addr", int'(addr_out), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_busy", int'(busy), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Wrap-around from ptr=0: rows 0 then 7
        ready = 1'b1;
        req   = 8'h81;
        exp_q.push_back(0);
        exp_q.push_back(7);
        tick();
        req = 8'h00;
        check("wrap_pending", int'(pending), 8'h81);
        drain("wrap");
        check("wrap_busy", int'(busy), 0);

        // Single request, observed cycle by cycle
        ready = 1'b0;
        req   = 8'h20;
        exp_q.push_back(5);
        tick();
        req = 8'h00;
        check("single_pending", int'(pending), 8'h20);
        check("single_valid_early", int'(valid), 0);
        tick();
        check("single_valid", int'(valid), 1);
        check("single_addr", int'(addr_out), 5);
        ready = 1'b1;
        tick();
        check("single_pending_clr", int'(pending), 0);
        check("single_valid_clr", int'(valid), 0);
        check("single_busy", int'(busy), 0);

        // Round-robin: grant row 2 (ptr -> 3), then 0x19 grants 3,4,0
        req = 8'h04;
        exp_q.push_back(2);
        tick();
        req = 8'h00;
        drain("rr_first");
        req = 8'h19;
        exp_q.push_back(3);
        exp_q.push_back(4);
        exp_q.push_back(0);
        tick();
        req = 8'h00;
        drain("rr_order");

        // Backpressure: row 1 held while row 6 arrives
        ready = 1'b0;
        req   = 8'h02;
        exp_q.push_back(1);
        tick();
        req = 8'h00;
        tick();
        req = 8'h40;
        exp_q.push_back(6);
        tick();
        req = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(valid), 1);
            check("bp_addr", int'(addr_out), 1);
            tick();
        end
        check("bp_pending", int'(pending), 8'h42);
        ready = 1'b1;
        drain("bp");

        // Same-edge accept and re-request of row 5
        ready = 1'b0;
        req   = 8'h20;
        exp_q.push_back(5);
        tick();
        req = 8'h00;
        tick();
        check("sc_addr", int'(addr_out), 5);
        ready = 1'b1;
        req   = 8'h20;
        exp_q.push_back(5);
        tick();
        req = 8'h00;
        check("sc_pending_kept", int'(pending), 8'h20);
        check("sc_valid_drop", int'(valid), 0);
        tick();
        check("sc_regrant_valid", int'(valid), 1);
        check("sc_regrant_addr", int'(addr_out), 5);
        drain("sc");
        check("sc_busy", int'(busy), 0);

        // Reset between edges while a grant is presented
        ready = 1'b0;
        req   = 8'h20;
        tick();
        req = 8'h04;
        tick();
        req = 8'h00;
        check("mid_valid", int'(valid), 1);
        check("mid_addr", int'(addr_out), 5);
        check("mid_pending", int'(pending), 8'h24);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", int'(valid), 0);
        check("async_addr", int'(addr_out), 0);
        check("async_pending", int'(pending), 0);
        check("async_busy", int'(busy), 0);
        tick();
        reset = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_valid", int'(valid), 0);
            check("post_rst_pending", int'(pending), 0);
        end
        req = 8'h08;
        exp_q.push_back(3);
        tick();
        req = 8'h00;
        drain("post_rst");
        check("final_busy", int'(busy), 0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/row_request_encoder.md
Name: row_request_encoder

Overview:
- Reverse direction of the row address decoder: collects per-row request lines (multi-hot, up to 8 rows) and encodes them, one at a time, into a 3-bit binary row address.
- Captured requests are held as sticky pending bits and served round-robin.
- Each address is presented with a valid/ready handshake so a downstream address decoder or memory controller can consume it.
- Sits between the row request sources (switches/keys or other logic) and the row address decoder.

Parameters:
- N, 8, number of request lines / rows; power of two, at least 2.
- AW, 3, address width; must equal clog2(N).

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  request lines, multi-hot; any bit high for at least one clock edge is captured.
- ready  in  1  downstream accepts addr_out when ready and valid are both high at an edge.
- addr_out  out  AW  binary index of the row being granted.
- valid  out  1  addr_out holds a grant.
- pending  out  N  registered sticky request bits not yet served.
- busy  out  1  combinational: (|pending) | valid.

Behaviour:
- Reset (async, any time, including mid-handshake): addr_out=0, valid=0, pending=0, rr pointer ptr=0, state=IDLE. Outputs change immediately, without waiting for a clock edge.
- Capture, every edge: pending <= (pending & ~clr) | req.
  - clr is one-hot of addr_out only on a handshake edge (valid & ready), otherwise 0.
  - Set wins: if req[k] is high on the same edge that row k is accepted, pending[k] stays 1 and row k is granted again later.
- FSM states: IDLE, PRESENT.
  - IDLE, pending==0: stay in IDLE; valid=0.
  - IDLE, pending!=0: pick the first set bit searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wraps mod N).
    - Register addr_out=index and valid=1; go to PRESENT.
    - The search uses the registered pending only, not the current req.
  - PRESENT, ready=0: hold addr_out and valid stable; valid must never drop without a handshake. pending keeps accumulating new requests.
  - PRESENT, ready=1: handshake. Clear pending[addr_out] (subject to set-wins), set ptr <= (addr_out+1) mod N, set valid <= 0, go to IDLE. addr_out keeps its last value.
- Latency: req high at edge t -> pending set after t -> valid=1 after edge t+1 (when IDLE and no competing row wins).
- Throughput: at most one grant per 2 cycles (one PRESENT cycle plus one IDLE cycle).
- ptr arithmetic is AW bits wide; N-1 wraps to 0 naturally.
- Fairness: a continuously pending row is granted within N grants.
- req bits high for several cycles set pending once. No counting: one pending bit per row.

Decomposition:
- Shared package (row_pkg): N_ROWS=8, ROW_AW=3, and the state enum {IDLE, PRESENT}. The existing decoder width is also drawn from N_ROWS/ROW_AW.
- One sub-module: rr_priority_encoder.
  - Purely combinational.
  - Inputs: pending[N], ptr[AW]. Outputs: idx[AW], found.
  - Implemented as a rotate, fixed-priority encode, then un-rotate.
- Top block contains the pending register, ptr, FSM and output registers.

Test Plan:
- Reset mid-operation: valid=1, addr_out=5, pending=0x24; assert reset between edges -> valid=0, addr_out=0, pending=0 immediately; no grant until req resumes after reset deasserts.
- Single request: req=0x20 for one cycle at edge t -> pending=0x20 after t; valid=1, addr_out=5 after t+1; ready=1 at t+2 -> pending=0, valid=0, ptr=6.
- Wrap-around: ptr=0, req=0x81 pulse -> grants addr 0 then 7 (ready tied high); ptr ends at 0; busy=0 afterwards.
- Round-robin order: serve row 2 first (ptr=3), then load pending=0x19 -> grant sequence 3, 4, 0.
- Backpressure: valid=1, addr_out=1, ready held low 5 cycles while req=0x40 pulses -> addr_out stays 1, valid stays 1, pending becomes 0x42; after ready -> next grant is 6.
- Simultaneous set/clear: row 5 presented, ready=1 and req=0x20 on the same edge -> pending[5] remains 1; row 5 is granted again (addr_out=5, valid=1 two edges later when no other row pending).
